unified_memory_pipelined: RTL and testbench
===========================================

Name: unified_memory_pipelined

Overview:
- Successor to the unified instruction/data memory: one word-organised store shared by an instruction port and a data port.
- Both ports use valid/ready requests and respond after a parametrised read latency.
- The block handles sub-word lane shifting, sign/zero extension, and misalignment and out-of-range faults itself.
- After reset, an init state machine fills the array with NOPs before it accepts any request.
- Sits between the core's fetch/LSU stages and the backing memory in simulation and FPGA builds.

Parameters:
- ADDR_WIDTH, 32, byte-address width of both ports.
- MEM_SIZE, 2097152, total bytes; a power of two and a multiple of 4. MEM_WORDS = MEM_SIZE/4.
- READ_LATENCY, 1, cycles from request accept to response valid; legal range 1..4.
- INIT_FILL, 1, 1 runs the NOP-fill FSM after reset; 0 skips straight to RUN.
- FILL_WORD, 32'h00000013, value written to every word during init.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- init_done  out  1  high once the block is in RUN.
- i_req_valid  in  1  instruction fetch request.
- i_req_ready  out  1  fetch request accepted when valid && ready.
- i_addr  in  ADDR_WIDTH  fetch byte address.
- i_rsp_valid  out  1  fetch response valid; one-cycle pulse per accepted request.
- i_rsp_data  out  32  fetched word.
- i_rsp_fault  out  1  fetch fault (misaligned or out of range).
- d_req_valid  in  1  data request.
- d_req_ready  out  1  data request accepted when valid && ready.
- d_addr  in  ADDR_WIDTH  data byte address.
- d_we  in  1  1 = store, 0 = load.
- d_funct3  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- d_wdata  in  32  store value, right-justified (low bits).
- d_rsp_valid  out  1  data response valid (loads and stores).
- d_rsp_rdata  out  32  extended load result; 0 for stores and faults.
- d_rsp_fault  out  1  data fault.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All response pipelines clear; every *_rsp_valid, *_rsp_data/rdata and *_rsp_fault output goes to 0.
  - init_done = 0; both req_ready = 0.
  - FSM enters INIT (INIT_FILL=1) or RUN (INIT_FILL=0) on the first edge after rst_n rises.
  - Array contents are not reset.
- FSM states:
  - INIT: a fill counter runs 0..MEM_WORDS-1 and writes FILL_WORD to one word per cycle; req_ready = 0.
  - INIT to RUN: on the edge that writes word MEM_WORDS-1. init_done and both req_ready rise in the following cycle and stay high in RUN.
  - Reset asserted mid-INIT: counter returns to 0 and the fill restarts from word 0.
- Throughput: fully pipelined. In RUN, each port accepts one request per cycle; there is no response backpressure.
- Response timing: a request accepted at edge N produces rsp_valid during the cycle after edge N+READ_LATENCY-1. READ_LATENCY=1 gives the response in the cycle after accept.
- Instruction port:
  - Word index = i_addr[..:2].
  - Fault if i_addr[1:0] != 0 or i_addr >= MEM_SIZE. On fault, i_rsp_data = 0 and i_rsp_fault = 1.
- Data alignment faults:
  - H/HU fault if addr[0] = 1.
  - W faults if addr[1:0] != 0.
  - Any access faults if addr >= MEM_SIZE.
  - Undefined d_funct3 (011, 110, 111) is a fault.
- Faulting store: write suppressed; response has fault = 1 and rdata = 0.
- Stores:
  - Commit on the accept edge.
  - Lanes: B writes lane addr[1:0] with d_wdata[7:0]. H writes lanes {addr[1],0} and {addr[1],1} with d_wdata[15:0]. W writes all four lanes.
  - Little-endian throughout.
  - A store still produces d_rsp_valid with rdata = 0 as an acknowledgement.
- Loads:
  - Select byte/half by addr[1:0], then sign-extend (B, H) or zero-extend (BU, HU).
- Same-edge conflicts:
  - Instruction read and data store to the same word on the same edge: the instruction port returns the old word (read-before-write).
  - A data load accepted on any edge after a store's accept edge returns the new data.
- Read-data capture: the array is read at accept time; the value is then carried through (READ_LATENCY-1) register stages.

Test Plan:
- Init: MEM_SIZE=64, INIT_FILL=1, reset released → init_done rises exactly 17 cycles later; an i-fetch at 0x3C returns 0x00000013, fault 0.
- Store/load: SW 0x8000_00FF at 0x10, then LB 0x10 → 0xFFFFFFFF, LBU 0x10 → 0x000000FF, LH 0x12 → 0xFFFF8000, LHU 0x12 → 0x00008000.
- Sub-word store: SB 0xAB at 0x21 over word 0x11223344 → LW 0x20 = 0x1122AB44. SH 0xBEEF at 0x22 → LW 0x20 = 0xBEEFAB44.
- Faults: LW 0x06, LH 0x05, i-fetch 0x02, SW at MEM_SIZE → each fault = 1, data 0; the following LW of the target word shows no change.
- Latency/conflict: READ_LATENCY=3, back-to-back fetches at 0x0, 0x4, 0x8 → three consecutive rsp_valid pulses, the first 3 cycles after accept. Same-edge SW 0xDEADBEEF and fetch at 0x8 → fetch returns the old word; the next fetch returns 0xDEADBEEF.
- Reset mid-INIT: assert rst_n low at fill count 5 → all outputs 0 immediately; after release the full 16-word fill repeats before init_done rises.

Source files
------------

// File: rtl/unified_memory_pipelined.sv
// unified_memory_pipelined
//   Word-organised memory shared by an instruction-fetch port and a data
//   (load/store) port. Both ports accept one request per cycle and answer
//   READ_LATENCY cycles later. Lane shifting, sign/zero extension, and
//   misalignment/range faults are handled here. After reset an optional fill
//   state machine writes FILL_WORD to every word before requests are accepted.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   init_done                       high while in RUN
//   i_req_valid/i_req_ready/i_addr  fetch request
//   i_rsp_valid/i_rsp_data/i_rsp_fault   fetch response
//   d_req_valid/d_req_ready/d_addr/d_we/d_funct3/d_wdata   data request
//   d_rsp_valid/d_rsp_rdata/d_rsp_fault  data response (loads and stores)
module unified_memory_pipelined #(
  parameter int          ADDR_WIDTH   = 32,
  parameter int          MEM_SIZE     = 2097152,
  parameter int          READ_LATENCY = 1,
  parameter int          INIT_FILL    = 1,
  parameter logic [31:0] FILL_WORD    = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_done,
  input  logic                  i_req_valid,
  output logic                  i_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_rsp_valid,
  output logic [31:0]           i_rsp_data,
  output logic                  i_rsp_fault,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic                  d_we,
  input  logic [2:0]            d_funct3,
  input  logic [31:0]           d_wdata,
  output logic                  d_rsp_valid,
  output logic [31:0]           d_rsp_rdata,
  output logic                  d_rsp_fault
);

  localparam int MEM_WORDS = MEM_SIZE / 4;
  localparam int BYTE_W    = $clog2(MEM_SIZE);
  localparam int IDX_W     = BYTE_W - 2;
  localparam int LAST      = READ_LATENCY - 1;

  // ---------------- control FSM ----------------
  typedef enum logic [1:0] {ST_RESET, ST_INIT, ST_RUN} state_t;
  state_t           state_reg, state_next;
  logic [IDX_W-1:0] fill_cnt_reg;
  logic             fill_we;
  logic             fill_last;

  assign fill_last = (fill_cnt_reg == {IDX_W{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_RESET;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RESET: state_next = (INIT_FILL != 0) ? ST_INIT : ST_RUN;
      ST_INIT:  if (fill_last) state_next = ST_RUN;
      ST_RUN:   state_next = ST_RUN;
      default:  state_next = ST_RESET;
    endcase
  end

  always_comb begin
    init_done = 1'b0;
    fill_we   = 1'b0;
    case (state_reg)
      ST_INIT: fill_we   = 1'b1;
      ST_RUN:  init_done = 1'b1;
      default: ;
    endcase
  end

  assign i_req_ready = init_done;
  assign d_req_ready = init_done;

  // Wraps back to 0 on the final fill write, leaving it clean for the next reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       fill_cnt_reg <= '0;
    else if (fill_we) fill_cnt_reg <= fill_cnt_reg + 1'b1;
  end

  // ---------------- request decode ----------------
  logic             i_acc, i_fault;
  logic [IDX_W-1:0] i_idx, d_idx;
  logic             d_acc, d_fault, d_oor, is_b, is_h, is_w, st_commit;
  logic [3:0]       st_be;
  logic [31:0]      st_data;

  assign i_acc   = i_req_valid & i_req_ready;
  assign i_idx   = i_addr[BYTE_W-1:2];
  assign i_fault = (|i_addr[ADDR_WIDTH-1:BYTE_W]) | (i_addr[1:0] != 2'b00);

  // funct3[2] only selects zero extension, so B/BU and H/HU share a size code.
  assign is_b  = (d_funct3[1:0] == 2'b00);
  assign is_h  = (d_funct3[1:0] == 2'b01);
  assign is_w  = (d_funct3 == 3'b010);
  assign d_oor = |d_addr[ADDR_WIDTH-1:BYTE_W];
  assign d_idx = d_addr[BYTE_W-1:2];
  assign d_fault = d_oor | ~(is_b | is_h | is_w)
                 | (is_h & d_addr[0])
                 | (is_w & (d_addr[1:0] != 2'b00));
  assign d_acc     = d_req_valid & d_req_ready;
  assign st_commit = d_acc & d_we & ~d_fault;

  // Store lanes: replicate the right-justified value across the word and
  // enable only the lanes the access covers.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign st_be[gi] = is_w
                     | (is_b & (d_addr[1:0] == 2'(gi)))
                     | (is_h & (d_addr[1] == 1'(gi / 2)));
    assign st_data[gi*8 +: 8] = is_b ? d_wdata[7:0]
                              : is_h ? d_wdata[8*(gi%2) +: 8]
                              :        d_wdata[8*gi +: 8];
  end

  // ---------------- storage and read-data pipeline ----------------
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [3:0]       wr_be;
  logic [31:0]      wr_data;

  assign wr_en   = fill_we | st_commit;
  assign wr_idx  = fill_we ? fill_cnt_reg : d_idx;
  assign wr_be   = fill_we ? 4'hF : st_be;
  assign wr_data = fill_we ? FILL_WORD : st_data;

  logic [31:0] mem [MEM_WORDS];
  logic [31:0] i_word_pipe [READ_LATENCY];
  logic [31:0] d_word_pipe [READ_LATENCY];

  // Reads sample the array before this edge's write lands, which gives the
  // fetch port read-before-write against a same-edge store.
  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (wr_en && wr_be[l]) mem[wr_idx][8*l +: 8] <= wr_data[8*l +: 8];
    end
    i_word_pipe[0] <= mem[i_idx];
    d_word_pipe[0] <= mem[d_idx];
    for (int k = 1; k < READ_LATENCY; k++) begin
      i_word_pipe[k] <= i_word_pipe[k-1];
      d_word_pipe[k] <= d_word_pipe[k-1];
    end
  end

  // Control pipelines: i = {valid, fault}; d = {valid, fault, we, funct3, offset}.
  logic [1:0] i_ctrl_pipe [READ_LATENCY];
  logic [7:0] d_ctrl_pipe [READ_LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        i_ctrl_pipe[k] <= '0;
        d_ctrl_pipe[k] <= '0;
      end
    end else begin
      i_ctrl_pipe[0] <= {i_acc, i_acc & i_fault};
      d_ctrl_pipe[0] <= {d_acc, d_acc & d_fault, d_we, d_funct3, d_addr[1:0]};
      for (int k = 1; k < READ_LATENCY; k++) begin
        i_ctrl_pipe[k] <= i_ctrl_pipe[k-1];
        d_ctrl_pipe[k] <= d_ctrl_pipe[k-1];
      end
    end
  end

  // ---------------- response formatting ----------------
  logic        d_v, d_f, d_w;
  logic [2:0]  d_f3;
  logic [1:0]  d_off;
  logic [31:0] d_word, d_ext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign i_rsp_valid = i_ctrl_pipe[LAST][1];
  assign i_rsp_fault = i_ctrl_pipe[LAST][0];
  assign i_rsp_data  = (i_rsp_valid & ~i_rsp_fault) ? i_word_pipe[LAST] : 32'h0;

  assign {d_v, d_f, d_w, d_f3, d_off} = d_ctrl_pipe[LAST];
  assign d_word   = d_word_pipe[LAST];
  assign byte_sel = d_word[{d_off, 3'b000} +: 8];
  assign half_sel = d_word[{d_off[1], 4'b0000} +: 16];

  always_comb begin
    d_ext = 32'h0;
    case (d_f3)
      3'b000:  d_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  d_ext = {24'h0, byte_sel};
      3'b001:  d_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  d_ext = {16'h0, half_sel};
      3'b010:  d_ext = d_word;
      default: d_ext = 32'h0;
    endcase
  end

  assign d_rsp_valid = d_v;
  assign d_rsp_fault = d_f;
  assign d_rsp_rdata = (d_v & ~d_f & ~d_w) ? d_ext : 32'h0;

endmodule

// File: tb/tb_unified_memory_pipelined.sv
module tb_unified_memory_pipelined;
  localparam int RL = 3;
  localparam int MS = 64;
  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010,
                         F_BU = 3'b100, F_HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_done;
  logic        i_req_valid = 1'b0, i_req_ready;
  logic [31:0] i_addr = '0;
  logic        i_rsp_valid, i_rsp_fault;
  logic [31:0] i_rsp_data;
  logic        d_req_valid = 1'b0, d_req_ready, d_we = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [2:0]  d_funct3 = '0;
  logic        d_rsp_valid, d_rsp_fault;
  logic [31:0] d_rsp_rdata;

  always #5 clk = ~clk;

  unified_memory_pipelined #(
    .ADDR_WIDTH(32), .MEM_SIZE(MS), .READ_LATENCY(RL),
    .INIT_FILL(1), .FILL_WORD(32'h00000013)
  ) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data), .i_rsp_fault(i_rsp_fault),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
    .d_we(d_we), .d_funct3(d_funct3), .d_wdata(d_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata), .d_rsp_fault(d_rsp_fault)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference model: a plain byte array, little-endian.
  logic [7:0] mem_m [MS];

  typedef struct {
    bit          iv;
    bit          ifl;
    logic [31:0] id;
    bit          dv;
    bit          dfl;
    logic [31:0] dd;
  } exp_t;

  exp_t q[$];

  function automatic logic [31:0] rd(input int a, input int n);
    logic [31:0] v = '0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = mem_m[a+k];
    return v;
  endfunction

  task automatic model_step(input bit iv, input logic [31:0] ia, input bit dv,
                            input logic [31:0] da, input bit dwe,
                            input logic [2:0] df3, input logic [31:0] dwd,
                            output exp_t e);
    int size;
    logic [31:0] v;
    e.iv = iv; e.ifl = 0; e.id = '0;
    e.dv = dv; e.dfl = 0; e.dd = '0;
    // The fetch is evaluated before the store so a same-edge store is not seen.
    if (iv) begin
      if (ia[1:0] != 2'b00 || ia >= 32'(MS)) e.ifl = 1;
      else e.id = rd(int'(ia), 4);
    end
    if (dv) begin
      case (df3)
        F_B, F_BU: size = 1;
        F_H, F_HU: size = 2;
        F_W:       size = 4;
        default:   size = 0;
      endcase
      if (size == 0 || da >= 32'(MS) || (int'(da[1:0]) % size) != 0) e.dfl = 1;
      else if (dwe) begin
        for (int k = 0; k < size; k++) mem_m[int'(da)+k] = dwd[8*k +: 8];
      end else begin
        v = rd(int'(da), size);
        if (!df3[2]) begin
          if (size == 1) v = {{24{v[7]}}, v[7:0]};
          else if (size == 2) v = {{16{v[15]}}, v[15:0]};
        end
        e.dd = v;
      end
    end
  endtask

  // One clock cycle: present a request pair, update the model at the edge,
  // and compare the response that is due READ_LATENCY edges after its accept.
  task automatic tick(input bit iv, input logic [31:0] ia, input bit dv,
                      input logic [31:0] da, input bit dwe,
                      input logic [2:0] df3, input logic [31:0] dwd);
    exp_t e, h;
    i_req_valid = iv; i_addr = ia;
    d_req_valid = dv; d_addr = da; d_we = dwe; d_funct3 = df3; d_wdata = dwd;
    @(posedge clk);
    model_step(iv, ia, dv, da, dwe, df3, dwd, e);
    q.push_back(e);
    @(negedge clk);
    if (q.size() == RL) begin
      h = q.pop_front();
      check("i_valid", {31'b0, i_rsp_valid}, {31'b0, h.iv});
      if (h.iv) begin
        check("i_data", i_rsp_data, h.id);
        check("i_fault", {31'b0, i_rsp_fault}, {31'b0, h.ifl});
      end
      check("d_valid", {31'b0, d_rsp_valid}, {31'b0, h.dv});
      if (h.dv) begin
        check("d_rdata", d_rsp_rdata, h.dd);
        check("d_fault", {31'b0, d_rsp_fault}, {31'b0, h.dfl});
      end
      if (h.iv || h.dv)
        $display("t=%0t rsp i(v=%0b data=%h flt=%0b) d(v=%0b rdata=%h flt=%0b)",
                 $time, i_rsp_valid, i_rsp_data, i_rsp_fault,
                 d_rsp_valid, d_rsp_rdata, d_rsp_fault);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_init_done"}, {31'b0, init_done}, 32'h0);
    check({tag, "_i_ready"}, {31'b0, i_req_ready}, 32'h0);
    check({tag, "_d_ready"}, {31'b0, d_req_ready}, 32'h0);
    check({tag, "_i_valid"}, {31'b0, i_rsp_valid}, 32'h0);
    check({tag, "_d_valid"}, {31'b0, d_rsp_valid}, 32'h0);
    check({tag, "_i_data"}, i_rsp_data, 32'h0);
    check({tag, "_d_rdata"}, d_rsp_rdata, 32'h0);
    check({tag, "_faults"}, {30'b0, i_rsp_fault, d_rsp_fault}, 32'h0);
  endtask

  initial begin
    int cnt;
    logic [31:0] ra, da;

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("rst");

    // Start a fill, then reset when the fill counter has reached 5
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("midinit_done", {31'b0, init_done}, 32'h0);
    rst_n = 1'b0;
    #1;
    check_all_zero("midinit_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Full fill of 16 words: init_done rises 17 edges after release
    cnt = 0;
    while (init_done !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("init_cycles", cnt, 32'd17);
    check("run_i_ready", {31'b0, i_req_ready}, 32'h1);
    check("run_d_ready", {31'b0, d_req_ready}, 32'h1);

    for (int b = 0; b < MS; b++) mem_m[b] = (b % 4 == 0) ? 8'h13 : 8'h00;

    // Filled word at the top of memory
    tick(1, 32'h3C, 0, 0, 0, F_W, 0);
    // Store / load extension
    tick(0, 0, 1, 32'h10, 1, F_W, 32'h800000FF);
    tick(0, 0, 1, 32'h10, 0, F_B, 0);
    tick(0, 0, 1, 32'h10, 0, F_BU, 0);
    tick(0, 0, 1, 32'h12, 0, F_H, 0);
    tick(0, 0, 1, 32'h12, 0, F_HU, 0);
    // Sub-word stores
    tick(0, 0, 1, 32'h20, 1, F_W, 32'h11223344);
    tick(0, 0, 1, 32'h21, 1, F_B, 32'hFFFFFFAB);
    tick(0, 0, 1, 32'h20, 0, F_W, 0);
    tick(0, 0, 1, 32'h22, 1, F_H, 32'h1234BEEF);
    tick(0, 0, 1, 32'h20, 0, F_W, 0);
    // Faults
    tick(0, 0, 1, 32'h06, 0, F_W, 0);
    tick(0, 0, 1, 32'h05, 0, F_H, 0);
    tick(1, 32'h02, 0, 0, 0, F_W, 0);
    tick(1, 32'h40, 1, 32'h40, 1, F_W, 32'h12345678);
    tick(0, 0, 1, 32'h04, 1, 3'b011, 32'hCAFEF00D);
    tick(0, 0, 1, 32'h04, 0, F_W, 0);
    tick(0, 0, 1, 32'h00, 0, F_W, 0);
    // Back-to-back fetches
    tick(1, 32'h0, 0, 0, 0, F_W, 0);
    tick(1, 32'h4, 0, 0, 0, F_W, 0);
    tick(1, 32'h8, 0, 0, 0, F_W, 0);
    // Same-edge store and fetch of one word, then refetch
    tick(1, 32'h8, 1, 32'h8, 1, F_W, 32'hDEADBEEF);
    tick(1, 32'h8, 0, 0, 0, F_W, 0);
    tick(0, 0, 1, 32'h8, 0, F_W, 0);

    // Randomized traffic on both ports
    for (int n = 0; n < 300; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 71))
                                       : 32'($urandom_range(0, 17) * 4);
      da = 32'($urandom_range(0, 71));
      tick($urandom_range(0, 1) == 1, ra, $urandom_range(0, 2) != 0, da,
           $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), $urandom);
    end
    repeat (RL) tick(0, 0, 0, 0, 0, F_W, 0);

    // Asynchronous reset while a response is being presented
    i_req_valid = 1'b1; i_addr = 32'h0;
    @(posedge clk);
    #1 i_req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("flight_i_valid", {31'b0, i_rsp_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_all_zero("flight_rst");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
